// File: rtl/lcd_cmd_arbiter_pkg.sv
// lcd_pkg: shared LCD command codes, arbiter state encoding and image size default.
package lcd_pkg;
  typedef logic [2:0] lcd_cmd_t;
  localparam lcd_cmd_t CMD_LOAD     = 3'd0;
  localparam lcd_cmd_t CMD_ZOOM_IN  = 3'd1;
  localparam lcd_cmd_t CMD_ZOOM_FIT = 3'd2;
  localparam lcd_cmd_t CMD_RIGHT    = 3'd3;
  localparam lcd_cmd_t CMD_LEFT     = 3'd4;
  localparam lcd_cmd_t CMD_UP       = 3'd5;
  localparam lcd_cmd_t CMD_DOWN     = 3'd6;
  localparam lcd_cmd_t CMD_REFRESH  = 3'd7;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam int IMG_SIZE_DEF = 108;
endpackage

// File: rtl/lcd_cmd_arbiter_if.sv
// lcd_cmd_arbiter_if: requester, image RAM and LCD_CTRL signals of the arbiter.
interface lcd_cmd_arbiter_if #(parameter int ADDR_W = 7);
  logic [1:0]        req_valid;
  logic [5:0]        req_cmd;
  logic [1:0]        req_ready;
  logic [15:0]       src_data;
  logic [1:0]        src_rd;
  logic [ADDR_W-1:0] src_addr;
  logic              lcd_busy;
  logic [2:0]        lcd_cmd;
  logic              lcd_cmd_valid;
  logic [7:0]        lcd_datain;
  logic              grant_id;
  logic              active;
  logic [1:0]        done;
  modport slave (
    input  req_valid, req_cmd, src_data, lcd_busy,
    output req_ready, src_rd, src_addr, lcd_cmd, lcd_cmd_valid, lcd_datain, grant_id, active, done
  );
  modport master (
    output req_valid, req_cmd, src_data, lcd_busy,
    input  req_ready, src_rd, src_addr, lcd_cmd, lcd_cmd_valid, lcd_datain, grant_id, active, done
  );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: per-requester command FIFO; pushes while full are dropped even if a pop coincides.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    dout = mem[rp];
  end
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin sharing of one LCD_CTRL between two requesters,
// including the gapless image RAM read sequence for LOAD_DATA.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_SIZE = IMG_SIZE_DEF,
  parameter int ADDR_W = 7
) (
  input logic clk,
  input logic reset,
  lcd_cmd_arbiter_if.slave bus
);
  logic [2:0]        state;
  lcd_cmd_t          cmd_r;
  logic              gid, rr;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        full, empty, pop, gsel;
  logic [2:0]        head [2];
  logic              has_req, pick, issue, fin;
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.req_valid[i]),
      .pop   (pop[i]),
      .din   (bus.req_cmd[3*i +: 3]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end
  always_comb begin
    has_req = ~&empty;
    pick = ~|empty ? rr : empty[0];
    pop = (state == S_IDLE && has_req) ? (pick ? 2'b10 : 2'b01) : 2'b00;
    issue = state == S_ISSUE && !bus.lcd_busy;
    fin = state == S_WAIT && !bus.lcd_busy;
    gsel = gid ? 2'b10 : 2'b01;
  end
  assign bus.req_ready = ~full;
  assign bus.lcd_cmd = cmd_r;
  assign bus.lcd_cmd_valid = issue;
  // Address 0 goes out with the command strobe so byte 0 lands the cycle LCD_CTRL starts capturing.
  assign bus.src_rd = ((issue && cmd_r == CMD_LOAD) || state == S_LOAD) ? gsel : 2'b00;
  assign bus.src_addr = state == S_LOAD ? addr : '0;
  assign bus.lcd_datain = gid ? bus.src_data[15:8] : bus.src_data[7:0];
  assign bus.grant_id = gid;
  assign bus.active = state != S_IDLE;
  assign bus.done = fin ? gsel : 2'b00;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cmd_r <= CMD_LOAD;
      gid <= 1'b0;
      rr <= 1'b0;
      addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (has_req) begin
          cmd_r <= pick ? head[1] : head[0];
          gid <= pick;
          state <= S_ISSUE;
        end
        S_ISSUE: if (!bus.lcd_busy) begin
          state <= cmd_r == CMD_LOAD ? S_LOAD : S_SETTLE;
          addr <= ADDR_W'(1);
        end
        S_LOAD: begin
          addr <= addr + 1'b1;
          state <= addr == ADDR_W'(IMG_SIZE - 1) ? S_SETTLE : S_LOAD;
        end
        S_SETTLE: state <= S_WAIT;
        S_WAIT: if (!bus.lcd_busy) begin
          rr <= ~gid;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/lcd_cmd_arbiter.md
Name: lcd_cmd_arbiter

Overview:
- Shares one LCD_CTRL instance between two command requesters (A=0, B=1).
- Each requester has its own command FIFO. Grants alternate round-robin.
- Drives LCD_CTRL cmd/cmd_valid, and holds the next command until LCD busy clears.
- For LOAD_DATA (cmd 0) it sequences a 108-byte read from the granted requester's image RAM onto datain, with no gaps. Each requester gets a done pulse when its command completes.

Parameters:
- FIFO_DEPTH, 4: command entries per requester; power of 2, minimum 2.
- IMG_SIZE, 108: bytes per LOAD_DATA transfer.
- ADDR_W, 7: image address width; ceil(log2(IMG_SIZE)).

Ports:
- clk  in  1  single clock; everything rises on posedge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state.
- req_valid  in  2  per-requester push strobe.
- req_cmd  in  6  {B[5:3], A[2:0]}; encoding 0 LOAD, 1 ZOOM_IN, 2 ZOOM_FIT, 3 RIGHT, 4 LEFT, 5 UP, 6 DOWN, 7 REFRESH.
- req_ready  out  2  per-requester "FIFO not full" (registered count).
- src_data  in  16  {B[15:8], A[7:0]}; image RAM read data, 1-cycle latency.
- src_rd  out  2  one-hot RAM read enable, granted requester only.
- src_addr  out  ADDR_W  RAM read address.
- lcd_busy  in  1  LCD_CTRL busy.
- lcd_cmd  out  3  command to LCD_CTRL.
- lcd_cmd_valid  out  1  one-cycle command strobe.
- lcd_datain  out  8  src_data byte of grant_id, combinational mux.
- grant_id  out  1  current/last granted requester.
- active  out  1  high from ISSUE until completion.
- done  out  2  one-cycle completion pulse, per requester.

Behaviour:
- Reset (reset=0):
  - FIFOs empty; state IDLE; rr pointer selects A first.
  - lcd_cmd=0, lcd_cmd_valid=0, src_rd=0, src_addr=0, grant_id=0, active=0, done=0, req_ready=2'b11.
- Push:
  - Entry accepted when req_valid[r] & req_ready[r].
  - When full, the push is dropped even if a pop happens in the same cycle.
  - A pop happens only on IDLE→ISSUE, taking the head of the granted FIFO.
- Arbitration in IDLE:
  - If exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the requester not granted last.
  - On grant: register the head into cmd_r, set grant_id, set active=1, go to ISSUE.
- ISSUE:
  - While lcd_busy=1, hold; lcd_cmd_valid stays 0.
  - When lcd_busy=0, assert lcd_cmd_valid=1 with lcd_cmd=cmd_r for exactly one cycle.
  - If cmd_r=0, also assert src_rd[grant_id]=1 with src_addr=0 in that same cycle, then go to LOAD.
  - Otherwise go to SETTLE.
- LOAD:
  - src_rd held high; src_addr steps 1..IMG_SIZE-1, one per cycle, for IMG_SIZE-1 cycles, then to SETTLE.
  - Byte k appears on lcd_datain in the cycle after address k, matching LCD_CTRL capture starting the cycle after cmd_valid.
  - src_rd and src_addr return to 0 on exit.
- SETTLE: one cycle, lcd_busy ignored (covers the busy-rise delay). Then WAIT.
- WAIT:
  - When lcd_busy=0, pulse done[grant_id] for 1 cycle, set active=0, update rr pointer, go to IDLE.
- Latency:
  - A non-LOAD push accepted in cycle 0 into an empty, idle arbiter gives lcd_cmd_valid in cycle 2.
  - Next grant is no earlier than 1 cycle after done.
- Commands are forwarded unchanged; legality (e.g., shift while zoom-fit) is LCD_CTRL's concern.
- Reset mid-operation: immediate clear, no done pulse. A partially issued LOAD is lost; the requester must re-push.

Decomposition:
- Shared package lcd_pkg:
  - LCD command localparams 0..7.
  - Arbiter state encoding: IDLE, ISSUE, LOAD, SETTLE, WAIT.
  - IMG_SIZE default.
- Sub-module lcd_cmd_fifo (DEPTH, width 3; push/pop/full/empty/count), instantiated twice.

Test Plan:
- Single command: A pushes 7 at cycle 0, lcd_busy model idle → lcd_cmd_valid=1, lcd_cmd=7 at cycle 2. Busy high cycles 3..18 → done[0] pulses at cycle 19.
- LOAD: A pushes 0; RAM A holds addr+1 → src_addr 0..107 on consecutive cycles. lcd_datain presents 1..108 on the 108 cycles after cmd_valid. Exactly one done[0].
- Round-robin: A pushes 3,4; B pushes 5,6 in the same cycle → issue order 3,5,4,6. grant_id alternates 0,1,0,1.
- Backpressure: lcd_busy forced high when entering ISSUE → lcd_cmd_valid stays 0 until busy falls, then issues exactly once.
- FIFO full: push 5 entries to A while LCD is stalled → req_ready[0]=0 after the 4th. The 5th is dropped; exactly 4 commands are issued.
- Reset mid-LOAD: reset=0 at src_addr=50 → src_rd=0, lcd_cmd_valid=0, FIFOs empty, no done. After release, a new push issues normally.
